// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel and receiver-state encodings plus the default sample width.
package i2s_pkg;

  localparam int SAMPLE_BITS_DEF = 16;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_chan_e;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } i2s_rx_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop input synchronizer. EDGE_MODE=1 emits a registered rising-edge strobe;
// EDGE_MODE=0 emits the synced level with identical latency so both outputs stay aligned.
module i2s_sync_edge #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0]                  lvl_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      lvl_p1  <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
      lvl_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  // p1: edge strobe or delayed level, both one flop past the synchronizer
  generate
    if (EDGE_MODE) begin : g_edge
      logic [WIDTH-1:0] rise_p1;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) rise_p1 <= '0;
        else      rise_p1 <= sync_p0[SYNC_STAGES-1] & ~lvl_p1;
      end
      assign q = rise_p1;
    end else begin : g_bare
      assign q = lvl_p1;
    end
  endgenerate

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S target-mode receiver: oversampled sck/ws/sd, standard I2S framing, L/R pair on valid/ready.
// Defining I2S_RX_FRAME_CHECK_EN adds frame_err and drops frames with short slots.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i2s_sck,
  input  logic                          i2s_ws,
  input  logic                          i2s_sd,
  output logic signed [SAMPLE_BITS-1:0] rx_sample_l,
  output logic signed [SAMPLE_BITS-1:0] rx_sample_r,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overflow
`ifdef I2S_RX_FRAME_CHECK_EN
  ,
  output logic                          frame_err
`endif
);

  localparam int CNT_W = $clog2(SAMPLE_BITS + 1);

  function automatic logic [SAMPLE_BITS-1:0] place_bit(
    input logic [SAMPLE_BITS-1:0] word,
    input logic [CNT_W-1:0]       pos,
    input logic                   b
  );
    logic [SAMPLE_BITS-1:0] w;
    w = word;
    for (int i = 0; i < SAMPLE_BITS; i++) begin
      if (SAMPLE_BITS - 1 - i == int'(pos)) w[i] = b;
    end
    return w;
  endfunction

  logic       strb_p1;
  logic [1:0] wssd_p1;
  logic       ws_p1;
  logic       sd_p1;

  i2s_sync_edge #(
    .WIDTH      (1),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MODE  (1'b1)
  ) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .din (i2s_sck),
    .q   (strb_p1)
  );

  i2s_sync_edge #(
    .WIDTH      (2),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MODE  (1'b0)
  ) u_sync_wssd (
    .clk (clk),
    .rst (rst),
    .din ({i2s_ws, i2s_sd}),
    .q   (wssd_p1)
  );

  assign ws_p1 = wssd_p1[1];
  assign sd_p1 = wssd_p1[0];

  // p2: framing FSM and per-channel deserializer
  i2s_rx_state_e                  state_p2;
  i2s_chan_e                      chan_p2;
  logic [CNT_W-1:0]               bit_cnt_p2;
  logic                           ws_prev_p2;
  logic                           ws_init_p2;
  logic                           lok_p2;
  logic signed [SAMPLE_BITS-1:0]  sh_p2;
  logic signed [SAMPLE_BITS-1:0]  lhold_p2;

  logic                           ws_chg;
  logic                           arm;
  logic                           take;
  logic                           full;
  logic                           done;
  logic                           commit;
  logic [CNT_W-1:0]               cnt_inc;
  logic signed [SAMPLE_BITS-1:0]  sh_nxt;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic                           short_slot;
`endif

  always_comb begin
    ws_chg  = ws_init_p2 && (ws_p1 != ws_prev_p2);
    arm     = strb_p1 && ws_chg;
    take    = strb_p1 && ((state_p2 == ARM) || (state_p2 == SHIFT));
    cnt_inc = bit_cnt_p2 + CNT_W'(1);
    full    = (cnt_inc == CNT_W'(SAMPLE_BITS));
    // The strobe that shows a ws change still carries the old channel's last bit.
    sh_nxt  = place_bit(sh_p2, bit_cnt_p2, sd_p1);
`ifdef I2S_RX_FRAME_CHECK_EN
    short_slot = take && ws_chg && !full;
    done       = take && full;
`else
    done       = take && (full || ws_chg);
`endif
    commit  = done && (chan_p2 == RIGHT) && lok_p2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p2   <= SEEK;
      chan_p2    <= LEFT;
      bit_cnt_p2 <= '0;
      ws_prev_p2 <= 1'b0;
      ws_init_p2 <= 1'b0;
      lok_p2     <= 1'b0;
    end else if (strb_p1) begin
      ws_prev_p2 <= ws_p1;
      ws_init_p2 <= 1'b1;
      if (ws_chg) begin
        state_p2   <= ARM;
        chan_p2    <= i2s_chan_e'(ws_p1);
        bit_cnt_p2 <= '0;
      end else if (take) begin
        state_p2   <= full ? HOLD : SHIFT;
        bit_cnt_p2 <= cnt_inc;
      end

      if (arm && (ws_p1 == 1'b0)) begin
        lok_p2 <= 1'b0;
      end else if (done) begin
        lok_p2 <= (chan_p2 == LEFT);
`ifdef I2S_RX_FRAME_CHECK_EN
      end else if (short_slot) begin
        lok_p2 <= 1'b0;
`endif
      end
    end
  end

  // Cleared on every slot start, so missing LSBs of a short slot read as zero.
  always_ff @(posedge clk) begin
    if (arm)       sh_p2 <= '0;
    else if (take) sh_p2 <= sh_nxt;
    if (done && (chan_p2 == LEFT)) lhold_p2 <= sh_nxt;
  end

  // p3: output holding register with valid/ready handshake
  logic signed [SAMPLE_BITS-1:0] smp_l_p3;
  logic signed [SAMPLE_BITS-1:0] smp_r_p3;
  logic                          vld_p3;
  logic                          ovf_p3;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic                          ferr_p3;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_l_p3 <= '0;
      smp_r_p3 <= '0;
      vld_p3   <= 1'b0;
      ovf_p3   <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
      ferr_p3  <= 1'b0;
`endif
    end else begin
      ovf_p3 <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
      ferr_p3 <= short_slot;
`endif
      if (commit) begin
        if (!vld_p3 || rx_ready) begin
          smp_l_p3 <= lhold_p2;
          smp_r_p3 <= sh_nxt;
          vld_p3   <= 1'b1;
        end else begin
          ovf_p3   <= 1'b1;
        end
      end else if (vld_p3 && rx_ready) begin
        vld_p3 <= 1'b0;
      end
    end
  end

  assign rx_sample_l = smp_l_p3;
  assign rx_sample_r = smp_r_p3;
  assign rx_valid    = vld_p3;
  assign rx_overflow = ovf_p3;
`ifdef I2S_RX_FRAME_CHECK_EN
  assign frame_err   = ferr_p3;
`endif

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Self-checking bench for i2s_slave_rx: drives I2S frames at clk/sck = 16 and scores received pairs.
module tb_i2s_slave_rx;

  localparam int SB = 16;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sck = 1'b0;
  logic ws  = 1'b1;
  logic sd  = 1'b0;
  logic rdy = 1'b1;
  logic signed [SB-1:0] rl;
  logic signed [SB-1:0] rr;
  logic vld;
  logic ovf;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic ferr;
  int   ferr_cnt = 0;
`endif

  always #5 clk = ~clk;

  i2s_slave_rx #(
    .SAMPLE_BITS(SB),
    .SYNC_STAGES(NS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i2s_sck    (sck),
    .i2s_ws     (ws),
    .i2s_sd     (sd),
    .rx_sample_l(rl),
    .rx_sample_r(rr),
    .rx_valid   (vld),
    .rx_ready   (rdy),
    .rx_overflow(ovf)
`ifdef I2S_RX_FRAME_CHECK_EN
    ,
    .frame_err  (ferr)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int vrise_cnt = 0;
  int vrise_cyc = 0;
  int ovf_cnt   = 0;
  logic vld_prev = 1'b0;
  logic [SB-1:0] hs_l[$];
  logic [SB-1:0] hs_r[$];
  logic [SB-1:0] exp_l[$];
  logic [SB-1:0] exp_r[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vld_prev <= vld;
    if (vld && !vld_prev) begin
      vrise_cnt <= vrise_cnt + 1;
      vrise_cyc <= cyc;
    end
    if (ovf) ovf_cnt <= ovf_cnt + 1;
`ifdef I2S_RX_FRAME_CHECK_EN
    if (ferr) ferr_cnt <= ferr_cnt + 1;
`endif
    if (vld && rdy) begin
      hs_l.push_back(rl);
      hs_r.push_back(rr);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic w, input logic d);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    clks(8);
    sck = 1'b1;
    rise_cyc = cyc;
    clks(8);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits, input logic wsv);
    for (int i = nbits - 1; i >= 0; i--) send_bit((i == 0) ? ~wsv : wsv, w[i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
    send_word(l, nbits, 1'b0);
    send_word(r, nbits, 1'b1);
  endtask

  task automatic preamble();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic ws_lvl);
    clks(1);
    rst = 1'b0;
    sck = 1'b0;
    ws  = ws_lvl;
    sd  = 1'b0;
    clks(3);
    rst = 1'b1;
    clks(2);
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    n_checks++; if (rl !== 16'h0) $display("FAIL reset_l got %h want 0000", rl); else n_pass++;
    n_checks++; if (rr !== 16'h0) $display("FAIL reset_r got %h want 0000", rr); else n_pass++;
    n_checks++; if (vld !== 1'b0) $display("FAIL reset_valid got %b want 0", vld); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
`ifdef I2S_RX_FRAME_CHECK_EN
    n_checks++; if (ferr !== 1'b0) $display("FAIL reset_ferr got %b want 0", ferr); else n_pass++;
`endif
  endtask

  task automatic test_basic();
    int base, vb, lat, n;
    logic [SB-1:0] el, er, al, ar;
    do_reset(1'b1);
    rdy = 1'b1;
    base = hs_l.size();
    vb = vrise_cnt;
    preamble();
    exp_l.push_back(16'h1234); exp_r.push_back(16'hABCD);
    send_frame(32'h1234, 32'hABCD, 16);
    clks(4);
    lat = vrise_cyc - rise_cyc;
    n_checks++; if (vrise_cnt - vb !== 1) $display("FAIL basic_vpulses got %0d want 1", vrise_cnt - vb); else n_pass++;
    n_checks++; if (lat < NS + 2 || lat > NS + 3) $display("FAIL basic_latency got %0d want %0d..%0d", lat, NS + 2, NS + 3); else n_pass++;
    n = hs_l.size() - base;
    n_checks++; if (n !== exp_l.size()) $display("FAIL basic_count got %0d want %0d", n, exp_l.size()); else n_pass++;
    while (exp_l.size() > 0) begin
      el = exp_l.pop_front(); er = exp_r.pop_front();
      if (base < hs_l.size()) begin al = hs_l[base]; ar = hs_r[base]; end else begin al = 'x; ar = 'x; end
      base++;
      n_checks++; if (al !== el) $display("FAIL basic_l got %h want %h", al, el); else n_pass++;
      n_checks++; if (ar !== er) $display("FAIL basic_r got %h want %h", ar, er); else n_pass++;
    end
  endtask

  task automatic test_wide();
    int base, ob, n;
    logic [SB-1:0] el, er, al, ar;
`ifdef I2S_RX_FRAME_CHECK_EN
    int fb;
    fb = ferr_cnt;
`endif
    do_reset(1'b1);
    rdy = 1'b1;
    base = hs_l.size();
    ob = ovf_cnt;
    preamble();
    exp_l.push_back(16'h8001); exp_r.push_back(16'h7FFE);
    send_frame(32'h8001_FFFF, 32'h7FFE_0000, 32);
    clks(4);
    n_checks++; if (ovf_cnt - ob !== 0) $display("FAIL wide_ovf got %0d want 0", ovf_cnt - ob); else n_pass++;
`ifdef I2S_RX_FRAME_CHECK_EN
    n_checks++; if (ferr_cnt - fb !== 0) $display("FAIL wide_ferr got %0d want 0", ferr_cnt - fb); else n_pass++;
`endif
    n = hs_l.size() - base;
    n_checks++; if (n !== exp_l.size()) $display("FAIL wide_count got %0d want %0d", n, exp_l.size()); else n_pass++;
    while (exp_l.size() > 0) begin
      el = exp_l.pop_front(); er = exp_r.pop_front();
      if (base < hs_l.size()) begin al = hs_l[base]; ar = hs_r[base]; end else begin al = 'x; ar = 'x; end
      base++;
      n_checks++; if (al !== el) $display("FAIL wide_l got %h want %h", al, el); else n_pass++;
      n_checks++; if (ar !== er) $display("FAIL wide_r got %h want %h", ar, er); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    int base, ob, n;
    logic [SB-1:0] el, er, al, ar;
    do_reset(1'b1);
    rdy = 1'b0;
    base = hs_l.size();
    ob = ovf_cnt;
    preamble();
    exp_l.push_back(16'h0001); exp_r.push_back(16'h0002);
    send_frame(32'h0001, 32'h0002, 16);
    send_frame(32'h0003, 32'h0004, 16);
    clks(4);
    n_checks++; if (vld !== 1'b1) $display("FAIL ovf_valid_held got %b want 1", vld); else n_pass++;
    n_checks++; if (rl !== 16'h0001) $display("FAIL ovf_l_held got %h want 0001", rl); else n_pass++;
    n_checks++; if (rr !== 16'h0002) $display("FAIL ovf_r_held got %h want 0002", rr); else n_pass++;
    n_checks++; if (ovf_cnt - ob !== 1) $display("FAIL ovf_pulses got %0d want 1", ovf_cnt - ob); else n_pass++;
    rdy = 1'b1;
    clks(1);
    n_checks++; if (vld !== 1'b0) $display("FAIL ovf_valid_drop got %b want 0", vld); else n_pass++;
    clks(2);
    n = hs_l.size() - base;
    n_checks++; if (n !== exp_l.size()) $display("FAIL ovf_count got %0d want %0d", n, exp_l.size()); else n_pass++;
    while (exp_l.size() > 0) begin
      el = exp_l.pop_front(); er = exp_r.pop_front();
      if (base < hs_l.size()) begin al = hs_l[base]; ar = hs_r[base]; end else begin al = 'x; ar = 'x; end
      base++;
      n_checks++; if (al !== el) $display("FAIL ovf_l got %h want %h", al, el); else n_pass++;
      n_checks++; if (ar !== er) $display("FAIL ovf_r got %h want %h", ar, er); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int base, vb, n;
    logic [31:0] w3;
    logic [SB-1:0] el, er, al, ar;
    do_reset(1'b1);
    rdy = 1'b0;
    preamble();
    send_frame(32'h1111, 32'h2222, 16);
    clks(4);
    n_checks++; if (vld !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", vld); else n_pass++;
    w3 = 32'h3333;
    for (int i = 15; i >= 11; i--) send_bit(1'b0, w3[i]);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (rl !== 16'h0) $display("FAIL mid_async_l got %h want 0000", rl); else n_pass++;
    n_checks++; if (rr !== 16'h0) $display("FAIL mid_async_r got %h want 0000", rr); else n_pass++;
    n_checks++; if (vld !== 1'b0) $display("FAIL mid_async_valid got %b want 0", vld); else n_pass++;
    sck = 1'b0;
    clks(3);
    rst = 1'b1;
    rdy = 1'b1;
    clks(2);
    base = hs_l.size();
    vb = vrise_cnt;
    for (int i = 10; i >= 0; i--) send_bit(i == 0, w3[i]);
    send_word(32'h4444, 16, 1'b1);
    exp_l.push_back(16'h5555); exp_r.push_back(16'h6666);
    send_frame(32'h5555, 32'h6666, 16);
    clks(4);
    n_checks++; if (vrise_cnt - vb !== 1) $display("FAIL mid_vpulses got %0d want 1", vrise_cnt - vb); else n_pass++;
    n = hs_l.size() - base;
    n_checks++; if (n !== exp_l.size()) $display("FAIL mid_count got %0d want %0d", n, exp_l.size()); else n_pass++;
    while (exp_l.size() > 0) begin
      el = exp_l.pop_front(); er = exp_r.pop_front();
      if (base < hs_l.size()) begin al = hs_l[base]; ar = hs_r[base]; end else begin al = 'x; ar = 'x; end
      base++;
      n_checks++; if (al !== el) $display("FAIL mid_l got %h want %h", al, el); else n_pass++;
      n_checks++; if (ar !== er) $display("FAIL mid_r got %h want %h", ar, er); else n_pass++;
    end
  endtask

  task automatic test_short_slot();
    int base, vb, n;
    logic [SB-1:0] el, er, al, ar;
`ifdef I2S_RX_FRAME_CHECK_EN
    int fb;
    fb = ferr_cnt;
`endif
    do_reset(1'b1);
    rdy = 1'b1;
    base = hs_l.size();
    vb = vrise_cnt;
    preamble();
`ifndef I2S_RX_FRAME_CHECK_EN
    exp_l.push_back(16'hABC0); exp_r.push_back(16'h1230);
`endif
    send_frame(32'hABC, 32'h123, 12);
    clks(4);
`ifdef I2S_RX_FRAME_CHECK_EN
    n_checks++; if (ferr_cnt - fb !== 2) $display("FAIL short_ferr got %0d want 2", ferr_cnt - fb); else n_pass++;
    n_checks++; if (vrise_cnt - vb !== 0) $display("FAIL short_vpulses got %0d want 0", vrise_cnt - vb); else n_pass++;
`else
    n_checks++; if (vrise_cnt - vb !== 1) $display("FAIL short_vpulses got %0d want 1", vrise_cnt - vb); else n_pass++;
`endif
    n = hs_l.size() - base;
    n_checks++; if (n !== exp_l.size()) $display("FAIL short_count got %0d want %0d", n, exp_l.size()); else n_pass++;
    while (exp_l.size() > 0) begin
      el = exp_l.pop_front(); er = exp_r.pop_front();
      if (base < hs_l.size()) begin al = hs_l[base]; ar = hs_r[base]; end else begin al = 'x; ar = 'x; end
      base++;
      n_checks++; if (al !== el) $display("FAIL short_l got %h want %h", al, el); else n_pass++;
      n_checks++; if (ar !== er) $display("FAIL short_r got %h want %h", ar, er); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int base, n;
    logic [SB-1:0] el, er, al, ar;
    do_reset(1'b1);
    rdy = 1'b1;
    base = hs_l.size();
    for (int i = 8; i >= 0; i--) send_bit(i != 0, 1'($urandom_range(0, 1)));
    exp_l.push_back(16'h0A0A); exp_r.push_back(16'h0B0B);
    send_frame(32'h0A0A, 32'h0B0B, 16);
    exp_l.push_back(16'h7FFF); exp_r.push_back(16'h8000);
    send_frame(32'h7FFF, 32'h8000, 16);
    clks(4);
    n = hs_l.size() - base;
    n_checks++; if (n !== exp_l.size()) $display("FAIL b2b_count got %0d want %0d", n, exp_l.size()); else n_pass++;
    while (exp_l.size() > 0) begin
      el = exp_l.pop_front(); er = exp_r.pop_front();
      if (base < hs_l.size()) begin al = hs_l[base]; ar = hs_r[base]; end else begin al = 'x; ar = 'x; end
      base++;
      n_checks++; if (al !== el) $display("FAIL b2b_l got %h want %h", al, el); else n_pass++;
      n_checks++; if (ar !== er) $display("FAIL b2b_r got %h want %h", ar, er); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_overflow();
    test_reset_mid();
    test_short_slot();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_slave_rx.md
# i2s_slave_rx

I2S target-mode receiver. It is the far end of the link driven by `i2s_transceiver`: it accepts externally generated `i2s_sck`/`i2s_ws`/`i2s_sd` and oversamples them with the system clock. It deserializes standard-I2S stereo frames and presents each left/right pair on a valid/ready parallel port. It sits at the codec or test-peer side of the I2S loop, in front of the sample-processing pipeline.

## Interface
- `SAMPLE_BITS`, 16, bits captured per channel, MSB first.
- `SYNC_STAGES`, 2, flip-flops in each input synchronizer (≥2).
- `clk`  in  1  system clock; must give ≥2 clk periods for each of sck high and sck low.
- `rst`  in  1  asynchronous, active-low reset.
- `i2s_sck`  in  1  bit clock from the I2S master, asynchronous to `clk`.
- `i2s_ws`  in  1  word select: 0 = left, 1 = right.
- `i2s_sd`  in  1  serial data.
- `rx_sample_l`  out  SAMPLE_BITS  signed left sample.
- `rx_sample_r`  out  SAMPLE_BITS  signed right sample.
- `rx_valid`  out  1  pair available.
- `rx_ready`  in  1  consumer accepts the pair.
- `rx_overflow`  out  1  one-cycle pulse when a completed pair is dropped.
- `frame_err`  out  1  one-cycle pulse on a short slot. Only present with `I2S_RX_FRAME_CHECK_EN`.

## Operation
- `sck`, `ws` and `sd` each pass through `SYNC_STAGES` flops with equal depth, so they stay mutually aligned.
- A rising edge of the synced `sck` is one bit strobe. `ws` and `sd` are sampled on that strobe.
- Standard I2S framing: when a strobe sees `ws` differ from its previous strobe value, the next strobe carries the MSB of the new channel.
- FSM states:
  - SEEK: reset state; ignores data. Moves to ARM on the first observed `ws` change.
  - ARM: latches the channel (new `ws` value) and clears `bit_cnt`. Moves to SHIFT.
  - SHIFT: each strobe shifts `sd` into that channel's register and increments `bit_cnt`. At `bit_cnt == SAMPLE_BITS` it moves to HOLD.
  - HOLD: ignores extra slot bits, so slots wider than SAMPLE_BITS are truncated to the MSBs. A `ws` change moves to ARM.
- A `ws` change while in SHIFT is a short slot:
  - Without the macro: the sample is zero-padded in the missing LSBs (left-justified) and treated as complete.
  - The FSM goes to ARM either way.
- Commit happens when the right channel completes (HOLD entry or short-slot close) and a complete left sample from the same frame is held.
- Commit with output register empty, or with a simultaneous `rx_valid && rx_ready` handshake: load `rx_sample_l`/`rx_sample_r` and assert `rx_valid`.
- Commit with `rx_valid` high and no handshake that cycle: keep the old pair, discard the new one, pulse `rx_overflow`.
- A right slot with no preceding left slot (first frame after SEEK) is discarded silently.
- `rx_valid` holds until `rx_valid && rx_ready`. Data stays stable while valid.
- Reset at any time returns to SEEK; any partial frame is lost.

## Timing
- Reset values: `rx_sample_l = 0`, `rx_sample_r = 0`, `rx_valid = 0`, `rx_overflow = 0`, `frame_err = 0`. FSM = SEEK, `bit_cnt = 0`, synchronizer flops = 0.
- Latency: `rx_valid` rises `SYNC_STAGES + 2` clk cycles after the sck edge that carries the last right bit reaches the pin, with +1 cycle sampling uncertainty.
- A handshake drops `rx_valid` the next cycle unless a commit lands in the same cycle.
- `rx_overflow` and `frame_err` are single-cycle registered pulses.
- `bit_cnt` width is clog2(SAMPLE_BITS+1). It saturates in HOLD and never wraps.

## Configuration
- `I2S_RX_FRAME_CHECK_EN` defined:
  - `frame_err` port exists.
  - A short slot pulses `frame_err`, clears the frame's left/right valid flags and drops the pair (no commit).
  - A `ws` change seen in ARM (zero-length slot) also flags.
- Not defined: no `frame_err` port; short slots are zero-padded and committed as described above.

## Structure
- Shared package `i2s_pkg`:
  - `i2s_chan_e` (LEFT = 0, RIGHT = 1).
  - `i2s_rx_state_e` (SEEK, ARM, SHIFT, HOLD).
  - Default `SAMPLE_BITS` constant, also used by `i2s_transceiver`.
- One sub-module, `i2s_sync_edge`: a parameterized `SYNC_STAGES` synchronizer plus rising-edge detector. It is instantiated for `sck`; `ws`/`sd` use its bare synchronizer mode so all three stay aligned.

## Test plan
- Clock ratio clk/sck = 16, SAMPLE_BITS 16, `rx_ready = 1`. Frame L = 0x1234, R = 0xABCD -> one `rx_valid` pulse with exactly L = 0x1234, R = 0xABCD, within `SYNC_STAGES + 3` cycles of the last right bit.
- 32-bit slots carrying L = 0x8001_FFFF, R = 0x7FFE_0000 -> L = 0x8001, R = 0x7FFE; no `frame_err`, no overflow.
- `rx_ready = 0` across two frames (0x0001/0x0002, then 0x0003/0x0004) -> outputs stay 0x0001/0x0002 and `rx_overflow` pulses once. After `rx_ready = 1`, `rx_valid` drops the next cycle.
- `rst` low mid-left-slot -> all outputs 0 asynchronously. After release, no `rx_valid` until a full left+right frame following a `ws` edge.
- 12-bit slots of 0xABC/0x123:
  - Macro on: `frame_err` pulses and no `rx_valid`.
  - Macro off: L = 0xABC0, R = 0x1230.
- Reset released with `ws = 1` mid-right-slot -> that partial frame is ignored; the first output is the next complete L/R pair.
